// File: rtl/rv_alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the integer pipeline (port 0)
// and the branch/address unit (port 1), with a one-entry response register per port.
module rv_alu_arbiter #(
   parameter int TAG_W = 4
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [31:0]      i_req0_src_a,
   input  logic [31:0]      i_req0_src_b,
   input  logic [5:0]       i_req0_ctrl,
   input  logic [TAG_W-1:0] i_req0_tag,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [31:0]      i_req1_src_a,
   input  logic [31:0]      i_req1_src_b,
   input  logic [5:0]       i_req1_ctrl,
   input  logic [TAG_W-1:0] i_req1_tag,
   output logic             o_rsp0_valid,
   input  logic             i_rsp0_ready,
   output logic [31:0]      o_rsp0_result,
   output logic             o_rsp0_zero,
   output logic [TAG_W-1:0] o_rsp0_tag,
   output logic             o_rsp1_valid,
   input  logic             i_rsp1_ready,
   output logic [31:0]      o_rsp1_result,
   output logic             o_rsp1_zero,
   output logic [TAG_W-1:0] o_rsp1_tag,
   output logic [31:0]      o_alu_src_a,
   output logic [31:0]      o_alu_src_b,
   output logic [5:0]       o_alu_ctrl,
   input  logic [31:0]      i_alu_result,
   input  logic             i_alu_zero
);

   // Handshake: a request transfers on a cycle where valid && ready; a response transfers
   // on a cycle where o_rspN_valid && i_rspN_ready. A slot may drain and refill in one cycle.

   logic             r_last;
   logic             r_rsp0_valid;
   logic [31:0]      r_rsp0_result;
   logic             r_rsp0_zero;
   logic [TAG_W-1:0] r_rsp0_tag;
   logic             r_rsp1_valid;
   logic [31:0]      r_rsp1_result;
   logic             r_rsp1_zero;
   logic [TAG_W-1:0] r_rsp1_tag;

   logic w_avail0;
   logic w_avail1;
   logic w_elig0;
   logic w_elig1;
   logic w_grant0;
   logic w_grant1;

   always_comb begin
      w_avail0 = !r_rsp0_valid || i_rsp0_ready;
      w_avail1 = !r_rsp1_valid || i_rsp1_ready;
      w_elig0  = i_req0_valid && w_avail0;
      w_elig1  = i_req1_valid && w_avail1;
      // r_last names the most recent winner; on a conflict the other port goes.
      w_grant0 = w_elig0 && (!w_elig1 || r_last);
      w_grant1 = w_elig1 && (!w_elig0 || !r_last);
   end

   assign o_req0_ready = w_grant0;
   assign o_req1_ready = w_grant1;

   assign o_alu_src_a = w_grant1 ? i_req1_src_a : i_req0_src_a;
   assign o_alu_src_b = w_grant1 ? i_req1_src_b : i_req0_src_b;
   assign o_alu_ctrl  = w_grant1 ? i_req1_ctrl  : i_req0_ctrl;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_last <= 1'b1;
      end else if (w_grant0) begin
         r_last <= 1'b0;
      end else if (w_grant1) begin
         r_last <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rsp0_valid  <= 1'b0;
         r_rsp0_result <= '0;
         r_rsp0_zero   <= 1'b0;
         r_rsp0_tag    <= '0;
      end else if (w_grant0) begin
         r_rsp0_valid  <= 1'b1;
         r_rsp0_result <= i_alu_result;
         r_rsp0_zero   <= i_alu_zero;
         r_rsp0_tag    <= i_req0_tag;
      end else if (r_rsp0_valid && i_rsp0_ready) begin
         r_rsp0_valid  <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rsp1_valid  <= 1'b0;
         r_rsp1_result <= '0;
         r_rsp1_zero   <= 1'b0;
         r_rsp1_tag    <= '0;
      end else if (w_grant1) begin
         r_rsp1_valid  <= 1'b1;
         r_rsp1_result <= i_alu_result;
         r_rsp1_zero   <= i_alu_zero;
         r_rsp1_tag    <= i_req1_tag;
      end else if (r_rsp1_valid && i_rsp1_ready) begin
         r_rsp1_valid  <= 1'b0;
      end
   end

   assign o_rsp0_valid  = r_rsp0_valid;
   assign o_rsp0_result = r_rsp0_result;
   assign o_rsp0_zero   = r_rsp0_zero;
   assign o_rsp0_tag    = r_rsp0_tag;
   assign o_rsp1_valid  = r_rsp1_valid;
   assign o_rsp1_result = r_rsp1_result;
   assign o_rsp1_zero   = r_rsp1_zero;
   assign o_rsp1_tag    = r_rsp1_tag;

endmodule

// File: tb/tb_rv_alu_arbiter.sv
// Bench for rv_alu_arbiter: a behavioural ALU closes the loop, directed scenarios check the
// listed cases and a randomized run is compared against a per-port response-queue model.
module tb_rv_alu_arbiter;

   localparam int TAG_W = 4;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_CMP = 3'd7;
   localparam logic [2:0] CMP_EQ = 3'd0, CMP_NE = 3'd1, CMP_LTS = 3'd2;
   localparam logic [2:0] CMP_LTU = 3'd3, CMP_GES = 3'd4, CMP_GEU = 3'd5;

   logic             i_clk = 1'b0;
   logic             i_reset_n = 1'b1;
   logic             i_req0_valid = 1'b0, i_req1_valid = 1'b0;
   logic             o_req0_ready, o_req1_ready;
   logic [31:0]      i_req0_src_a = '0, i_req0_src_b = '0, i_req1_src_a = '0, i_req1_src_b = '0;
   logic [5:0]       i_req0_ctrl = '0, i_req1_ctrl = '0;
   logic [TAG_W-1:0] i_req0_tag = '0, i_req1_tag = '0;
   logic             o_rsp0_valid, o_rsp1_valid;
   logic             i_rsp0_ready = 1'b1, i_rsp1_ready = 1'b1;
   logic [31:0]      o_rsp0_result, o_rsp1_result;
   logic             o_rsp0_zero, o_rsp1_zero;
   logic [TAG_W-1:0] o_rsp0_tag, o_rsp1_tag;
   logic [31:0]      o_alu_src_a, o_alu_src_b;
   logic [5:0]       o_alu_ctrl;
   logic [31:0]      i_alu_result;
   logic             i_alu_zero;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q0[$];
   logic [36:0] exp_q1[$];

   rv_alu_arbiter #(.TAG_W(TAG_W)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
      .i_req0_src_a(i_req0_src_a), .i_req0_src_b(i_req0_src_b),
      .i_req0_ctrl(i_req0_ctrl), .i_req0_tag(i_req0_tag),
      .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
      .i_req1_src_a(i_req1_src_a), .i_req1_src_b(i_req1_src_b),
      .i_req1_ctrl(i_req1_ctrl), .i_req1_tag(i_req1_tag),
      .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
      .o_rsp0_result(o_rsp0_result), .o_rsp0_zero(o_rsp0_zero), .o_rsp0_tag(o_rsp0_tag),
      .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
      .o_rsp1_result(o_rsp1_result), .o_rsp1_zero(o_rsp1_zero), .o_rsp1_tag(o_rsp1_tag),
      .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_ctrl(o_alu_ctrl),
      .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] ctrl);
      logic c;
      c = 1'b0;
      case (ctrl[5:3])
         CMP_EQ:  c = (a == b);
         CMP_NE:  c = (a != b);
         CMP_LTS: c = ($signed(a) < $signed(b));
         CMP_LTU: c = (a < b);
         CMP_GES: c = ($signed(a) >= $signed(b));
         CMP_GEU: c = (a >= b);
         default: c = 1'b0;
      endcase
      case (ctrl[2:0])
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         default: return {31'd0, c};
      endcase
   endfunction

   always_comb begin
      i_alu_result = alu_fn(o_alu_src_a, o_alu_src_b, o_alu_ctrl);
      i_alu_zero   = (i_alu_result == 32'd0);
   end

   task automatic idle_inputs();
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b0;
      i_rsp0_ready = 1'b1;
      i_rsp1_ready = 1'b1;
   endtask

   task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] c, input logic [3:0] t);
      i_req0_valid = v; i_req0_src_a = a; i_req0_src_b = b; i_req0_ctrl = c; i_req0_tag = t;
   endtask

   task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] c, input logic [3:0] t);
      i_req1_valid = v; i_req1_src_a = a; i_req1_src_b = b; i_req1_ctrl = c; i_req1_tag = t;
   endtask

   task automatic next_cycle();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      idle_inputs();
      i_reset_n = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      idle_inputs();
      i_reset_n = 1'b0;
      #1;
      checks++;
      if ({o_rsp1_valid, o_rsp0_valid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_valids: got %b expected 00", {o_rsp1_valid, o_rsp0_valid});
      end
      checks++;
      if ({o_rsp0_result, o_rsp0_zero, o_rsp0_tag, o_rsp1_result, o_rsp1_zero, o_rsp1_tag} !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h/%b/%h %h/%b/%h expected zeros", o_rsp0_result,
                  o_rsp0_zero, o_rsp0_tag, o_rsp1_result, o_rsp1_zero, o_rsp1_tag);
      end
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
   endtask

   task automatic test_conflict();
      do_reset();
      drive0(1'b1, 32'd1, 32'd1, {3'd0, OP_ADD}, 4'h1);
      drive1(1'b1, 32'd7, 32'd7, {3'd0, OP_XOR}, 4'h2);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({o_req1_ready, o_req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL conflict_grant[%0d]: got %b expected %b", i,
                     {o_req1_ready, o_req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
         end
         if (i % 2 == 1) begin
            checks++;
            if ({o_rsp0_valid, o_rsp0_result, o_rsp0_zero, o_rsp0_tag} !== {1'b1, 32'd2, 1'b0, 4'h1}) begin
               errors++;
               $display("FAIL conflict_rsp0[%0d]: got v=%b r=%h z=%b t=%h expected v=1 r=2 z=0 t=1",
                        i, o_rsp0_valid, o_rsp0_result, o_rsp0_zero, o_rsp0_tag);
            end
         end else if (i > 0) begin
            checks++;
            if ({o_rsp1_valid, o_rsp1_result, o_rsp1_zero, o_rsp1_tag} !== {1'b1, 32'd0, 1'b1, 4'h2}) begin
               errors++;
               $display("FAIL conflict_rsp1[%0d]: got v=%b r=%h z=%b t=%h expected v=1 r=0 z=1 t=2",
                        i, o_rsp1_valid, o_rsp1_result, o_rsp1_zero, o_rsp1_tag);
            end
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_single_op();
      idle_inputs();
      drive0(1'b1, 32'd5, 32'd3, {3'd0, OP_SUB}, 4'hA);
      #1;
      checks++;
      if ({o_req1_ready, o_req0_ready, o_alu_src_a, o_alu_ctrl} !== {2'b01, 32'd5, {3'd0, OP_SUB}}) begin
         errors++;
         $display("FAIL single_accept: got rdy=%b a=%h ctrl=%h expected rdy=01 a=5 ctrl=%h",
                  {o_req1_ready, o_req0_ready}, o_alu_src_a, o_alu_ctrl, {3'd0, OP_SUB});
      end
      next_cycle();
      i_req0_valid = 1'b0;
      #1;
      checks++;
      if ({o_rsp0_valid, o_rsp0_result, o_rsp0_zero, o_rsp0_tag} !== {1'b1, 32'd2, 1'b0, 4'hA}) begin
         errors++;
         $display("FAIL single_rsp: got v=%b r=%h z=%b t=%h expected v=1 r=2 z=0 t=a",
                  o_rsp0_valid, o_rsp0_result, o_rsp0_zero, o_rsp0_tag);
      end
      next_cycle();
      #1;
      checks++;
      if (o_rsp0_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got v=%b expected 0", o_rsp0_valid);
      end
   endtask

   task automatic test_backpressure();
      idle_inputs();
      i_rsp0_ready = 1'b0;
      drive0(1'b1, 32'd10, 32'd20, {3'd0, OP_ADD}, 4'h1);
      #1;
      checks++;
      if (o_req0_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first_accept: got %b expected 1", o_req0_ready);
      end
      next_cycle();
      drive0(1'b1, 32'd50, 32'd8, {3'd0, OP_SUB}, 4'h2);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if ({o_req0_ready, o_rsp0_valid, o_rsp0_result, o_rsp0_tag} !== {1'b0, 1'b1, 32'd30, 4'h1}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got rdy=%b v=%b r=%h t=%h expected rdy=0 v=1 r=1e t=1",
                     k, o_req0_ready, o_rsp0_valid, o_rsp0_result, o_rsp0_tag);
         end
         next_cycle();
      end
      i_rsp0_ready = 1'b1;
      #1;
      checks++;
      if ({o_req0_ready, o_rsp0_valid, o_rsp0_result} !== {1'b1, 1'b1, 32'd30}) begin
         errors++;
         $display("FAIL bp_release: got rdy=%b v=%b r=%h expected rdy=1 v=1 r=1e",
                  o_req0_ready, o_rsp0_valid, o_rsp0_result);
      end
      next_cycle();
      i_req0_valid = 1'b0;
      #1;
      checks++;
      if ({o_rsp0_valid, o_rsp0_result, o_rsp0_tag} !== {1'b1, 32'd42, 4'h2}) begin
         errors++;
         $display("FAIL bp_second_rsp: got v=%b r=%h t=%h expected v=1 r=2a t=2",
                  o_rsp0_valid, o_rsp0_result, o_rsp0_tag);
      end
      next_cycle();
   endtask

   task automatic test_blocked_yield();
      idle_inputs();
      i_rsp0_ready = 1'b0;
      drive0(1'b1, 32'd3, 32'd4, {3'd0, OP_ADD}, 4'h5);
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         drive1(1'b1, 32'(k), 32'd1, {3'd0, OP_ADD}, 4'(k));
         #1;
         checks++;
         if ({o_req1_ready, o_req0_ready, o_rsp0_valid, o_rsp0_result} !== {2'b10, 1'b1, 32'd7}) begin
            errors++;
            $display("FAIL yield[%0d]: got rdy=%b v0=%b r0=%h expected rdy=10 v0=1 r0=7",
                     k, {o_req1_ready, o_req0_ready}, o_rsp0_valid, o_rsp0_result);
         end
         if (k > 0) begin
            checks++;
            if ({o_rsp1_valid, o_rsp1_result, o_rsp1_tag} !== {1'b1, 32'(k), 4'(k - 1)}) begin
               errors++;
               $display("FAIL yield_rsp1[%0d]: got v=%b r=%h t=%h expected v=1 r=%h t=%h",
                        k, o_rsp1_valid, o_rsp1_result, o_rsp1_tag, k, k - 1);
            end
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_compare();
      idle_inputs();
      drive1(1'b1, 32'hFFFF_FFFF, 32'd1, {CMP_LTS, OP_CMP}, 4'h3);
      #1;
      checks++;
      if ({o_req1_ready, o_alu_src_a, o_alu_ctrl} !== {1'b1, 32'hFFFF_FFFF, {CMP_LTS, OP_CMP}}) begin
         errors++;
         $display("FAIL cmp_drive: got rdy=%b a=%h ctrl=%h expected rdy=1 a=ffffffff ctrl=%h",
                  o_req1_ready, o_alu_src_a, o_alu_ctrl, {CMP_LTS, OP_CMP});
      end
      next_cycle();
      drive1(1'b1, 32'hFFFF_FFFF, 32'd1, {CMP_LTU, OP_CMP}, 4'h4);
      #1;
      checks++;
      if ({o_rsp1_valid, o_rsp1_result, o_rsp1_zero, o_rsp1_tag} !== {1'b1, 32'd1, 1'b0, 4'h3}) begin
         errors++;
         $display("FAIL cmp_lts: got v=%b r=%h z=%b t=%h expected v=1 r=1 z=0 t=3",
                  o_rsp1_valid, o_rsp1_result, o_rsp1_zero, o_rsp1_tag);
      end
      next_cycle();
      idle_inputs();
      #1;
      checks++;
      if ({o_rsp1_valid, o_rsp1_result, o_rsp1_zero, o_rsp1_tag} !== {1'b1, 32'd0, 1'b1, 4'h4}) begin
         errors++;
         $display("FAIL cmp_ltu: got v=%b r=%h z=%b t=%h expected v=1 r=0 z=1 t=4",
                  o_rsp1_valid, o_rsp1_result, o_rsp1_zero, o_rsp1_tag);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      i_rsp0_ready = 1'b0;
      i_rsp1_ready = 1'b0;
      drive0(1'b1, 32'd1, 32'd2, {3'd0, OP_ADD}, 4'h6);
      drive1(1'b1, 32'd4, 32'd5, {3'd0, OP_ADD}, 4'h7);
      next_cycle();
      next_cycle();
      #1;
      checks++;
      if ({o_rsp1_valid, o_rsp0_valid} !== 2'b11) begin
         errors++;
         $display("FAIL mid_fill: got %b expected 11", {o_rsp1_valid, o_rsp0_valid});
      end
      #1;
      i_reset_n = 1'b0;
      #1;
      checks++;
      if ({o_rsp1_valid, o_rsp0_valid} !== 2'b00) begin
         errors++;
         $display("FAIL mid_async_clear: got %b expected 00", {o_rsp1_valid, o_rsp0_valid});
      end
      next_cycle();
      i_reset_n = 1'b1;
      i_rsp0_ready = 1'b1;
      i_rsp1_ready = 1'b1;
      #1;
      checks++;
      if ({o_req1_ready, o_req0_ready} !== 2'b01) begin
         errors++;
         $display("FAIL mid_first_grant: got %b expected 01", {o_req1_ready, o_req0_ready});
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   // Model: each port owns a queue of outstanding responses (at most one entry); a port can
   // take a request when its queue is empty or being drained, and ties go to the port that
   // did not win most recently.
   task automatic test_random();
      int win;
      int last;
      logic busy0, busy1, elig0, elig1;
      logic [1:0] exp_rdy;
      do_reset();
      exp_q0.delete();
      exp_q1.delete();
      last = 1;
      for (int n = 0; n < 400; n++) begin
         i_req0_valid = ($urandom_range(0, 9) < 7);
         i_req1_valid = ($urandom_range(0, 9) < 7);
         i_rsp0_ready = ($urandom_range(0, 9) < 6);
         i_rsp1_ready = ($urandom_range(0, 9) < 6);
         i_req0_src_a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
         i_req0_src_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
         i_req1_src_a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
         i_req1_src_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
         i_req0_ctrl  = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 7))};
         i_req1_ctrl  = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 7))};
         i_req0_tag   = 4'($urandom_range(0, 15));
         i_req1_tag   = 4'($urandom_range(0, 15));
         #1;
         busy0 = (exp_q0.size() != 0);
         busy1 = (exp_q1.size() != 0);
         elig0 = i_req0_valid && (!busy0 || i_rsp0_ready);
         elig1 = i_req1_valid && (!busy1 || i_rsp1_ready);
         if (elig0 && elig1) win = 1 - last;
         else if (elig0)     win = 0;
         else if (elig1)     win = 1;
         else                win = -1;
         exp_rdy = {win == 1, win == 0};
         checks++;
         if ({o_req1_ready, o_req0_ready} !== exp_rdy) begin
            errors++;
            $display("FAIL rand_grant[%0d]: got %b expected %b", n, {o_req1_ready, o_req0_ready}, exp_rdy);
         end
         checks++;
         if ({o_rsp1_valid, o_rsp0_valid} !== {busy1, busy0}) begin
            errors++;
            $display("FAIL rand_valid[%0d]: got %b expected %b", n, {o_rsp1_valid, o_rsp0_valid}, {busy1, busy0});
         end
         if (busy0) begin
            checks++;
            if ({o_rsp0_result, o_rsp0_zero, o_rsp0_tag} !== exp_q0[0]) begin
               errors++;
               $display("FAIL rand_rsp0[%0d]: got %h expected %h", n,
                        {o_rsp0_result, o_rsp0_zero, o_rsp0_tag}, exp_q0[0]);
            end
         end
         if (busy1) begin
            checks++;
            if ({o_rsp1_result, o_rsp1_zero, o_rsp1_tag} !== exp_q1[0]) begin
               errors++;
               $display("FAIL rand_rsp1[%0d]: got %h expected %h", n,
                        {o_rsp1_result, o_rsp1_zero, o_rsp1_tag}, exp_q1[0]);
            end
         end
         if (win >= 0) begin
            checks++;
            if (o_alu_ctrl !== ((win == 1) ? i_req1_ctrl : i_req0_ctrl)) begin
               errors++;
               $display("FAIL rand_alu_ctrl[%0d]: got %h expected %h", n, o_alu_ctrl,
                        (win == 1) ? i_req1_ctrl : i_req0_ctrl);
            end
         end
         if (busy0 && i_rsp0_ready) void'(exp_q0.pop_front());
         if (busy1 && i_rsp1_ready) void'(exp_q1.pop_front());
         if (win == 0) begin
            exp_q0.push_back({alu_fn(i_req0_src_a, i_req0_src_b, i_req0_ctrl),
                              alu_fn(i_req0_src_a, i_req0_src_b, i_req0_ctrl) == 32'd0, i_req0_tag});
            last = 0;
         end else if (win == 1) begin
            exp_q1.push_back({alu_fn(i_req1_src_a, i_req1_src_b, i_req1_ctrl),
                              alu_fn(i_req1_src_a, i_req1_src_b, i_req1_ctrl) == 32'd0, i_req1_tag});
            last = 1;
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_conflict();
      test_single_op();
      test_backpressure();
      test_blocked_yield();
      test_compare();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
